// File: rtl/ccc_dyncfg_ctrl_if.sv
// ----------------------------------------------------------------------------
// ccc_dyncfg_ctrl_if
// Bundles the request and CCC serial-port signals of ccc_dyncfg_ctrl.
//   CFG_REQ      start request from the configuration register block
//   CFG_WORD     configuration image to shift into the CCC
//   LOCK         CCC lock (asynchronous to CLK)
//   SDOUT        CCC serial configuration output
//   SCLK/SDIN    serial configuration clock / data
//   SSHIFT       shift enable
//   SUPDATE      update strobe
//   MODE         dynamic-configuration select
//   BUSY/DONE    status; DONE is a one-cycle success pulse
//   TIMEOUT_ERR  sticky lock-timeout flag
//   READBACK     previous configuration shifted out of the CCC
// modport slave  : controller side
// modport master : environment side (register block + CCC macro)
// ----------------------------------------------------------------------------
interface ccc_dyncfg_ctrl_if #(
    parameter int unsigned CFG_WIDTH = 81
) ();
    logic                 CFG_REQ;
    logic [CFG_WIDTH-1:0] CFG_WORD;
    logic                 LOCK;
    logic                 SDOUT;
    logic                 SCLK;
    logic                 SDIN;
    logic                 SSHIFT;
    logic                 SUPDATE;
    logic                 MODE;
    logic                 BUSY;
    logic                 DONE;
    logic                 TIMEOUT_ERR;
    logic [CFG_WIDTH-1:0] READBACK;

    modport slave (
        input  CFG_REQ, CFG_WORD, LOCK, SDOUT,
        output SCLK, SDIN, SSHIFT, SUPDATE, MODE, BUSY, DONE, TIMEOUT_ERR, READBACK
    );

    modport master (
        output CFG_REQ, CFG_WORD, LOCK, SDOUT,
        input  SCLK, SDIN, SSHIFT, SUPDATE, MODE, BUSY, DONE, TIMEOUT_ERR, READBACK
    );
endinterface

// File: rtl/ccc_dyncfg_ctrl.sv
// ----------------------------------------------------------------------------
// ccc_dyncfg_ctrl
// Reprograms the CCC/PLL through its dynamic-configuration serial port:
// shifts a captured configuration word in LSB first, pulses the update
// strobe, then waits for a stable PLL lock (with timeout). The previous
// configuration coming out on SDOUT is collected into READBACK.
// Ports:
//   CLK    system clock, rising edge
//   RESET  synchronous, active-high reset
//   bus    ccc_dyncfg_ctrl_if.slave (request, CCC serial port, status)
// ----------------------------------------------------------------------------
module ccc_dyncfg_ctrl #(
    parameter int unsigned CFG_WIDTH    = 81,
    parameter int unsigned SCLK_HALF    = 4,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic             CLK,
    input  logic             RESET,
    ccc_dyncfg_ctrl_if.slave bus
);
    localparam int unsigned BW = (CFG_WIDTH    > 1) ? $clog2(CFG_WIDTH)    : 1;
    localparam int unsigned PW = (SCLK_HALF    > 1) ? $clog2(SCLK_HALF)    : 1;
    localparam int unsigned UW = $clog2(2 * SCLK_HALF);
    localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [BW-1:0] BIT_LAST   = BW'(CFG_WIDTH - 1);
    localparam logic [PW-1:0] PH_LAST    = PW'(SCLK_HALF - 1);
    localparam logic [UW-1:0] UPD_LAST   = UW'(2 * SCLK_HALF - 1);
    localparam logic [SW-1:0] STABLE_TGT = SW'(LOCK_STABLE);
    localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_UPDATE,
        ST_WAIT_LOCK
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [CFG_WIDTH-1:0] r_sr;       // outgoing image, shifted right per bit
    logic [CFG_WIDTH-1:0] r_rb;       // readback, SDOUT enters at the MSB
    logic [BW-1:0]        r_bit;      // current bit index
    logic [PW-1:0]        r_ph;       // cycle within current SCLK half-period
    logic                 r_half;     // 0 = SCLK low phase, 1 = high phase
    logic [UW-1:0]        r_upd;      // SUPDATE cycle counter
    logic [SW-1:0]        r_stable;   // consecutive synchronized LOCK-high cycles
    logic [TW-1:0]        r_cyc;      // WAIT_LOCK cycle counter
    logic                 r_lock_s1;
    logic                 r_lock_s2;
    logic                 r_mode;
    logic                 r_done;
    logic                 r_toerr;

    logic                 w_accept;
    logic                 w_ph_end;
    logic                 w_bit_end;
    logic                 w_rise;
    logic                 w_lock_ok;
    logic                 w_lock_to;
    logic [SW-1:0]        w_stable_nxt;
    logic                 w_sclk;
    logic                 w_sdin;
    logic                 w_sshift;
    logic                 w_supdate;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and serial-port outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_ph_end     = (r_ph == PH_LAST);
        w_bit_end    = 1'b0;
        w_rise       = 1'b0;
        w_lock_ok    = 1'b0;
        w_lock_to    = 1'b0;
        w_stable_nxt = r_lock_s2 ? (r_stable + SW'(1)) : '0;
        w_sclk       = 1'b0;
        w_sdin       = 1'b0;
        w_sshift     = 1'b0;
        w_supdate    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.CFG_REQ) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                w_sshift  = 1'b1;
                w_sclk    = r_half;
                w_sdin    = r_sr[0];
                // first cycle of the high phase is the SCLK rising edge
                w_rise    = r_half && (r_ph == '0);
                w_bit_end = r_half && w_ph_end;
                if (w_bit_end && (r_bit == BIT_LAST)) begin
                    w_state_nxt = ST_UPDATE;
                end
            end

            ST_UPDATE: begin
                w_supdate = 1'b1;
                if (r_upd == UPD_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end

            ST_WAIT_LOCK: begin
                // success is tested first so it wins over a same-cycle timeout
                if (w_stable_nxt == STABLE_TGT) begin
                    w_lock_ok   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cyc == TO_LAST) begin
                    w_lock_to   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift/readback registers, counters, status flags
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sr      <= '0;
            r_rb      <= '0;
            r_bit     <= '0;
            r_ph      <= '0;
            r_half    <= 1'b0;
            r_upd     <= '0;
            r_stable  <= '0;
            r_cyc     <= '0;
            r_lock_s1 <= 1'b0;
            r_lock_s2 <= 1'b0;
            r_mode    <= 1'b0;
            r_done    <= 1'b0;
            r_toerr   <= 1'b0;
        end else begin
            r_lock_s1 <= bus.LOCK;
            r_lock_s2 <= r_lock_s1;
            r_done    <= w_lock_ok;

            if (w_accept) begin
                r_sr    <= bus.CFG_WORD;
                r_toerr <= 1'b0;
                r_mode  <= 1'b1;
                r_bit   <= '0;
                r_ph    <= '0;
                r_half  <= 1'b0;
            end else if (r_state == ST_SHIFT) begin
                if (w_ph_end) begin
                    r_ph   <= '0;
                    r_half <= ~r_half;
                    if (r_half) begin
                        r_sr  <= r_sr >> 1;
                        r_bit <= (r_bit == BIT_LAST) ? '0 : (r_bit + BW'(1));
                    end
                end else begin
                    r_ph <= r_ph + PW'(1);
                end
            end

            if (w_rise) begin
                r_rb <= {bus.SDOUT, r_rb[CFG_WIDTH-1:1]};
            end

            if ((r_state == ST_UPDATE) && (r_upd != UPD_LAST)) begin
                r_upd <= r_upd + UW'(1);
            end else begin
                r_upd <= '0;
            end

            // counters only live while WAIT_LOCK persists; cleared on exit
            if ((r_state == ST_WAIT_LOCK) && (w_state_nxt == ST_WAIT_LOCK)) begin
                r_stable <= w_stable_nxt;
                r_cyc    <= r_cyc + TW'(1);
            end else begin
                r_stable <= '0;
                r_cyc    <= '0;
            end

            if (w_lock_to) begin
                r_toerr <= 1'b1;
            end
        end
    end

    assign bus.SCLK        = w_sclk;
    assign bus.SDIN        = w_sdin;
    assign bus.SSHIFT      = w_sshift;
    assign bus.SUPDATE     = w_supdate;
    assign bus.MODE        = r_mode;
    assign bus.BUSY        = (r_state != ST_IDLE);
    assign bus.DONE        = r_done;
    assign bus.TIMEOUT_ERR = r_toerr;
    assign bus.READBACK    = r_rb;

endmodule
